// File: rtl/lw_hmac_ks.sv
// lw_hmac_ks - HMAC sequencer with a NUM_KEYS-slot key store.
//
// Drives an external streaming hash core (which pads its own input) through
// the inner pass (key^ipad, message) and the outer pass (key^opad, inner
// digest). Keys are pre-loaded one word at a time and can be zeroized.
//
// Ports:
//   clk_i, reset_i             clock, synchronous active-high reset (also erases keys)
//   key_wr_i/key_slot_i/key_idx_i/key_i   write one key word into a slot
//   key_zeroize_i              clear the whole slot key_slot_i and its valid bit
//   key_valid_o                per-slot valid bits
//   start_i/slot_i             begin an HMAC with slot_i (IDLE only)
//   abort_i                    abandon the running operation
//   msg_valid_i/msg_data_i/msg_last_i/msg_ready_o   caller message stream
//   core_start_o/core_valid_o/core_data_o/core_last_o/core_ready_i  core input stream
//   core_done_i/core_digest_i  core completion and digest
//   core_abort_o               abort forwarded to the core
//   busy_o, done_o, err_o      status (done_o / err_o are single-cycle pulses)
//   hmac_o                     last completed result
module lw_hmac_ks #(
  parameter int WORD_SIZE    = 32,
  parameter int DIGEST_WORDS = 8,
  parameter int NUM_KEYS     = 4,
  localparam int SW          = $clog2(NUM_KEYS),
  localparam int DW          = DIGEST_WORDS * WORD_SIZE
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 key_wr_i,
  input  logic [SW-1:0]        key_slot_i,
  input  logic [3:0]           key_idx_i,
  input  logic [WORD_SIZE-1:0] key_i,
  input  logic                 key_zeroize_i,
  output logic [NUM_KEYS-1:0]  key_valid_o,
  input  logic                 start_i,
  input  logic [SW-1:0]        slot_i,
  input  logic                 abort_i,
  input  logic                 msg_valid_i,
  input  logic [WORD_SIZE-1:0] msg_data_i,
  input  logic                 msg_last_i,
  output logic                 msg_ready_o,
  output logic                 core_start_o,
  output logic                 core_valid_o,
  output logic [WORD_SIZE-1:0] core_data_o,
  output logic                 core_last_o,
  input  logic                 core_ready_i,
  input  logic                 core_done_i,
  input  logic [DW-1:0]        core_digest_i,
  output logic                 core_abort_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [DW-1:0]        hmac_o
);

  localparam logic [WORD_SIZE-1:0] IPAD_C   = {(WORD_SIZE/8){8'h36}};
  localparam logic [WORD_SIZE-1:0] OPAD_C   = {(WORD_SIZE/8){8'h5c}};
  localparam logic [3:0]           DIG_LAST = 4'(DIGEST_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IPAD     = 3'd1,
    ST_MSG      = 3'd2,
    ST_WAIT_IN  = 3'd3,
    ST_OPAD     = 3'd4,
    ST_DIG      = 3'd5,
    ST_WAIT_OUT = 3'd6
  } state_t;

  state_t               state_r, state_s;
  logic [3:0]           cnt_r, cnt_s;
  logic [SW-1:0]        slot_r;
  logic [WORD_SIZE-1:0] key_mem_r [NUM_KEYS][16];
  logic [NUM_KEYS-1:0]  key_valid_r;
  logic [DW-1:0]        inner_r, hmac_r;
  logic                 core_start_r, core_abort_r, done_r, err_r, busy_r;

  logic                 core_start_s, abort_s, latch_inner_s, latch_hmac_s;
  logic                 start_err_s, done_err_s, key_err_s;
  logic                 core_valid_s, core_last_s, msg_ready_s, xfer_s;
  logic [WORD_SIZE-1:0] core_data_s, key_word_s;
  logic [DW-1:0]        inner_sh_s;

  assign key_word_s = key_mem_r[slot_r][cnt_r];
  // Shift the wanted digest word to the top so DIG sends most-significant first.
  assign inner_sh_s = inner_r << (WORD_SIZE * int'(cnt_r));
  assign xfer_s     = core_valid_s & core_ready_i;
  // A key update aimed at the slot in use would corrupt the running HMAC.
  assign key_err_s  = busy_r & (key_wr_i | key_zeroize_i) & (key_slot_i == slot_r);
  assign done_err_s = core_done_i & (state_r != ST_WAIT_IN) & (state_r != ST_WAIT_OUT);

  // Core-side stream mux: padded key words, message passthrough, inner digest.
  always_comb begin
    core_valid_s = 1'b0;
    core_data_s  = {WORD_SIZE{1'b0}};
    core_last_s  = 1'b0;
    msg_ready_s  = 1'b0;
    case (state_r)
      // The entry cycle carries core_start_o, so the first word follows it.
      ST_IPAD: begin
        core_valid_s = ~core_start_r;
        core_data_s  = key_word_s ^ IPAD_C;
      end
      ST_MSG: begin
        core_valid_s = msg_valid_i;
        core_data_s  = msg_data_i;
        core_last_s  = msg_last_i;
        msg_ready_s  = core_ready_i;
      end
      ST_OPAD: begin
        core_valid_s = ~core_start_r;
        core_data_s  = key_word_s ^ OPAD_C;
      end
      ST_DIG: begin
        core_valid_s = 1'b1;
        core_data_s  = inner_sh_s[DW-1 -: WORD_SIZE];
        core_last_s  = (cnt_r == DIG_LAST);
      end
      default: core_valid_s = 1'b0;
    endcase
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    core_start_s  = 1'b0;
    abort_s       = 1'b0;
    latch_inner_s = 1'b0;
    latch_hmac_s  = 1'b0;
    start_err_s   = 1'b0;
    if ((state_r != ST_IDLE) && abort_i) begin
      state_s = ST_IDLE;
      cnt_s   = 4'd0;
      abort_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i && key_valid_r[slot_i]) begin
            state_s      = ST_IPAD;
            cnt_s        = 4'd0;
            core_start_s = 1'b1;
          end else begin
            start_err_s = start_i;
          end
        end
        ST_IPAD, ST_OPAD: begin
          if (xfer_s) begin
            cnt_s = cnt_r + 4'd1;  // 15 -> 0 wrap doubles as the reload
            if (cnt_r == 4'd15) begin
              state_s = (state_r == ST_IPAD) ? ST_MSG : ST_DIG;
            end else begin
              state_s = state_r;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_MSG: begin
          if (xfer_s && msg_last_i) begin
            state_s = ST_WAIT_IN;
            cnt_s   = 4'd0;
          end else begin
            state_s = ST_MSG;
          end
        end
        ST_WAIT_IN: begin
          if (core_done_i) begin
            state_s       = ST_OPAD;
            cnt_s         = 4'd0;
            core_start_s  = 1'b1;
            latch_inner_s = 1'b1;
          end else begin
            state_s = ST_WAIT_IN;
          end
        end
        ST_DIG: begin
          if (xfer_s && (cnt_r == DIG_LAST)) begin
            state_s = ST_WAIT_OUT;
            cnt_s   = 4'd0;
          end else if (xfer_s) begin
            cnt_s = cnt_r + 4'd1;
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_WAIT_OUT: begin
          if (core_done_i) begin
            state_s      = ST_IDLE;
            cnt_s        = 4'd0;
            latch_hmac_s = 1'b1;
          end else begin
            state_s = ST_WAIT_OUT;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
        end
      endcase
    end
  end

  // FSM state, status pulses, latched slot and digest registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      slot_r       <= {SW{1'b0}};
      inner_r      <= {DW{1'b0}};
      hmac_r       <= {DW{1'b0}};
      core_start_r <= 1'b0;
      core_abort_r <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      core_start_r <= core_start_s;
      core_abort_r <= abort_s;
      done_r       <= latch_hmac_s;
      err_r        <= start_err_s | done_err_s | key_err_s;
      busy_r       <= (state_s != ST_IDLE);
      if (core_start_s && (state_r == ST_IDLE)) slot_r <= slot_i;
      if (abort_s) inner_r <= {DW{1'b0}};
      else if (latch_inner_s) inner_r <= core_digest_i;
      if (latch_hmac_s) hmac_r <= core_digest_i;
    end
  end

  // Key store: word writes, whole-slot zeroize (beats a same-cycle write), valid bits.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int s = 0; s < NUM_KEYS; s++) begin
        for (int w = 0; w < 16; w++) key_mem_r[s][w] <= {WORD_SIZE{1'b0}};
      end
      key_valid_r <= {NUM_KEYS{1'b0}};
    end else if (!key_err_s) begin
      if (key_zeroize_i) begin
        for (int w = 0; w < 16; w++) key_mem_r[key_slot_i][w] <= {WORD_SIZE{1'b0}};
        key_valid_r[key_slot_i] <= 1'b0;
      end else if (key_wr_i) begin
        key_mem_r[key_slot_i][key_idx_i] <= key_i;
        key_valid_r[key_slot_i]          <= 1'b1;
      end
    end
  end

  assign key_valid_o  = key_valid_r;
  assign msg_ready_o  = msg_ready_s;
  assign core_start_o = core_start_r;
  assign core_valid_o = core_valid_s;
  assign core_data_o  = core_data_s;
  assign core_last_o  = core_last_s;
  assign core_abort_o = core_abort_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign err_o        = err_r;
  assign hmac_o       = hmac_r;

endmodule

// File: tb/tb_lw_hmac_ks.sv
// tb_lw_hmac_ks - bench for lw_hmac_ks with a SHA-256 core model, a message
// driver and a scoreboard that checks hmac_o on every done_o pulse.
`timescale 1ns/1ps
module tb_lw_hmac_ks;
  localparam int WS = 32, DWD = 8, NK = 4, SW = 2, DW = 256;
  localparam logic [DW-1:0] HMAC_JEFE =
    256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843;
  localparam logic [DW-1:0] HMAC_HI =
    256'hb0344c61d8db38535ca8afceaf0bf12b881dc200c9833da726e9376c2e32cff7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i, key_wr_i, key_zeroize_i, start_i, abort_i;
  logic [SW-1:0] key_slot_i, slot_i;
  logic [3:0] key_idx_i;
  logic [WS-1:0] key_i, msg_data_i, core_data_o;
  logic [NK-1:0] key_valid_o;
  logic msg_valid_i, msg_last_i, msg_ready_o, core_start_o, core_valid_o, core_last_o;
  logic core_ready_i, core_done_i, core_abort_o, busy_o, done_o, err_o;
  logic [DW-1:0] core_digest_i, hmac_o;

  lw_hmac_ks #(.WORD_SIZE(WS), .DIGEST_WORDS(DWD), .NUM_KEYS(NK)) dut (
    .clk_i(clk), .reset_i(reset_i), .key_wr_i(key_wr_i), .key_slot_i(key_slot_i),
    .key_idx_i(key_idx_i), .key_i(key_i), .key_zeroize_i(key_zeroize_i),
    .key_valid_o(key_valid_o), .start_i(start_i), .slot_i(slot_i), .abort_i(abort_i),
    .msg_valid_i(msg_valid_i), .msg_data_i(msg_data_i), .msg_last_i(msg_last_i),
    .msg_ready_o(msg_ready_o), .core_start_o(core_start_o), .core_valid_o(core_valid_o),
    .core_data_o(core_data_o), .core_last_o(core_last_o), .core_ready_i(core_ready_i),
    .core_done_i(core_done_i), .core_digest_i(core_digest_i), .core_abort_o(core_abort_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .hmac_o(hmac_o)
  );

  int n_vec = 0, n_miss = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- SHA-256 reference (core model) ----------------
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256(input logic [31:0] msg[$]);
    logic [31:0] m[$];
    logic [31:0] h[8];
    logic [31:0] w[64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    int n;
    m = msg;
    n = msg.size();
    m.push_back(32'h8000_0000);
    while ((m.size() % 16) != 14) m.push_back(32'h0);
    m.push_back(32'h0);
    m.push_back(32'(n * 32));
    h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int blk = 0; blk < m.size() / 16; blk++) begin
      for (int i = 0; i < 16; i++) w[i] = m[blk*16 + i];
      for (int i = 16; i < 64; i++) begin
        s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
        s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
        w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int i = 0; i < 64; i++) begin
        s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
        t1 = hh + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
        s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
        t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  // ---------------- core stub ----------------
  logic [31:0] core_buf[$];
  int pass_cnt = 0, done_cd = 0;
  logic [DW-1:0] pend_dig;
  logic rand_ready = 1'b0, inject_done = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_data;

  initial begin
    core_ready_i = 1'b0; core_done_i = 1'b0; core_digest_i = '0; pend_dig = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (reset_i || core_abort_o) begin
        core_buf.delete(); done_cd = 0; prev_stall = 1'b0;
      end else begin
        if (core_start_o) begin core_buf.delete(); pass_cnt++; end
        if (prev_stall) begin
          check("stall_valid_held", DW'(core_valid_o), DW'(1'b1));
          check("stall_data_held", DW'(core_data_o), DW'(prev_data));
        end
        if (core_valid_o && core_ready_i) begin
          core_buf.push_back(core_data_o);
          if (core_last_o) begin pend_dig = sha256(core_buf); done_cd = 3; end
        end
        prev_stall = core_valid_o && !core_ready_i;
        prev_data  = core_data_o;
      end
      @(posedge clk); #1;
      core_done_i = 1'b0;
      if (done_cd > 0) begin
        done_cd--;
        if (done_cd == 0) begin core_done_i = 1'b1; core_digest_i = pend_dig; end
      end
      if (inject_done) begin core_done_i = 1'b1; core_digest_i = {DW{1'b1}}; inject_done = 1'b0; end
      core_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- message driver ----------------
  typedef struct packed { logic [31:0] d; logic l; } mword_t;
  mword_t msg_q[$];
  int msg_acc = 0;

  initial begin
    msg_valid_i = 1'b0; msg_data_i = '0; msg_last_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (msg_q.size() > 0) begin
        msg_valid_i = 1'b1; msg_data_i = msg_q[0].d; msg_last_i = msg_q[0].l;
      end else begin
        msg_valid_i = 1'b0; msg_data_i = '0; msg_last_i = 1'b0;
      end
      @(negedge clk);
      if (msg_valid_i && msg_ready_o) begin void'(msg_q.pop_front()); msg_acc++; end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [DW-1:0] exp_q[$];
  int done_seen = 0, abort_seen = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (done_o) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_done: got hmac %0h, required no done_o", hmac_o);
        end else begin
          check("hmac_result", hmac_o, exp_q.pop_front());
        end
      end
      if (core_abort_o) abort_seen++;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic key_write(input logic [1:0] s, input int idx, input logic [31:0] v);
    key_wr_i = 1'b1; key_slot_i = s; key_idx_i = 4'(idx); key_i = v;
    cyc();
    key_wr_i = 1'b0;
  endtask

  task automatic push_msg(input logic [31:0] w[$], input bit with_last);
    mword_t mw;
    for (int i = 0; i < w.size(); i++) begin
      mw.d = w[i];
      mw.l = with_last && (i == w.size() - 1);
      msg_q.push_back(mw);
    end
  endtask

  task automatic start(input logic [1:0] s);
    start_i = 1'b1; slot_i = s;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic wait_results(input string name, input int budget);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin cyc(); k++; end
    if (exp_q.size() > 0) begin
      n_vec++; n_miss++;
      $display("FAIL %s_timeout: %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_hmac(input logic [1:0] s, input logic [31:0] m[$],
                          input logic [DW-1:0] exp, input string name);
    int d0 = done_seen;
    exp_q.push_back(exp);
    push_msg(m, 1'b1);
    start(s);
    check({name, "_core_start_t1"}, DW'(core_start_o), DW'(1'b1));
    check({name, "_valid_low_t1"}, DW'(core_valid_o), DW'(1'b0));
    check({name, "_busy_t1"}, DW'(busy_o), DW'(1'b1));
    cyc();
    check({name, "_valid_t2"}, DW'(core_valid_o), DW'(1'b1));
    wait_results(name, 3000);
    check({name, "_busy_after"}, DW'(busy_o), DW'(1'b0));
    cyc(2);
    check({name, "_done_count"}, DW'(done_seen - d0), DW'(1));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, DW'(busy_o), '0);
    check({name, "_done"}, DW'(done_o), '0);
    check({name, "_err"}, DW'(err_o), '0);
    check({name, "_core_start"}, DW'(core_start_o), '0);
    check({name, "_core_valid"}, DW'(core_valid_o), '0);
    check({name, "_core_last"}, DW'(core_last_o), '0);
    check({name, "_core_abort"}, DW'(core_abort_o), '0);
    check({name, "_msg_ready"}, DW'(msg_ready_o), '0);
    check({name, "_key_valid"}, DW'(key_valid_o), '0);
    check({name, "_hmac"}, hmac_o, '0);
  endtask

  logic [31:0] m_jefe[$], m_hi[$];
  int k, a0, d0;

  initial begin
    m_jefe = '{32'h77686174, 32'h20646f20, 32'h79612077, 32'h616e7420,
               32'h666f7220, 32'h6e6f7468, 32'h696e673f};
    m_hi   = '{32'h48692054, 32'h68657265};
    reset_i = 1'b1; key_wr_i = 1'b0; key_zeroize_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    key_slot_i = '0; slot_i = '0; key_idx_i = '0; key_i = '0;
    cyc(3);
    reset_i = 1'b0;
    cyc();
    check_all_zero("reset");

    for (int i = 0; i < 16; i++) key_write(2'd0, i, (i == 0) ? 32'h4a656665 : 32'h0);
    for (int i = 0; i < 16; i++) key_write(2'd2, i, (i < 5) ? 32'h0b0b0b0b : 32'h0);
    check("key_valid_loaded", DW'(key_valid_o), DW'(4'b0101));

    // Scenario 1: "Jefe", core always ready.
    run_hmac(2'd0, m_jefe, HMAC_JEFE, "jefe");

    // Scenario 2: 20 x 0x0b, "Hi There", core_ready_i toggling randomly.
    rand_ready = 1'b1;
    run_hmac(2'd2, m_hi, HMAC_HI, "hi_there_stall");
    rand_ready = 1'b0;
    cyc(2);

    // Start on an unwritten slot.
    start(2'd3);
    check("bad_slot_err", DW'(err_o), DW'(1'b1));
    check("bad_slot_core_start", DW'(core_start_o), DW'(1'b0));
    check("bad_slot_busy", DW'(busy_o), DW'(1'b0));
    cyc();
    check("bad_slot_err_pulse", DW'(err_o), DW'(1'b0));
    check("bad_slot_busy_after", DW'(busy_o), DW'(1'b0));

    // Abort during MSG after three accepted words.
    a0 = abort_seen; d0 = done_seen;
    push_msg(m_jefe[0:2], 1'b0);
    k = msg_acc;
    start(2'd0);
    for (int i = 0; i < 200 && msg_acc < k + 3; i++) cyc();
    check("abort_words_accepted", DW'(msg_acc - k), DW'(3));
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    check("abort_core_abort", DW'(core_abort_o), DW'(1'b1));
    check("abort_busy", DW'(busy_o), DW'(1'b0));
    check("abort_hmac_kept", hmac_o, HMAC_HI);
    cyc();
    check("abort_pulse_len", DW'(core_abort_o), DW'(1'b0));
    cyc(10);
    check("abort_count", DW'(abort_seen - a0), DW'(1));
    check("abort_no_done", DW'(done_seen - d0), DW'(0));
    run_hmac(2'd0, m_jefe, HMAC_JEFE, "jefe_after_abort");

    // Zeroize of the active slot while busy is refused.
    exp_q.push_back(HMAC_HI);
    push_msg(m_hi, 1'b1);
    start(2'd2);
    cyc(2);
    key_zeroize_i = 1'b1; key_slot_i = 2'd2;
    cyc();
    key_zeroize_i = 1'b0;
    check("zero_busy_err", DW'(err_o), DW'(1'b1));
    check("zero_busy_valid_kept", DW'(key_valid_o), DW'(4'b0101));
    wait_results("zero_busy", 3000);

    // Zeroize slot 0 while idle, then start on it.
    cyc(2);
    key_zeroize_i = 1'b1; key_slot_i = 2'd0;
    cyc();
    key_zeroize_i = 1'b0;
    check("zero_idle_valid", DW'(key_valid_o), DW'(4'b0100));
    start(2'd0);
    check("zero_idle_start_err", DW'(err_o), DW'(1'b1));
    check("zero_idle_no_start", DW'(core_start_o), DW'(1'b0));
    check("zero_idle_busy", DW'(busy_o), DW'(1'b0));

    // Spurious core_done_i during IPAD; the run still completes correctly.
    cyc(2);
    exp_q.push_back(HMAC_HI);
    push_msg(m_hi, 1'b1);
    start(2'd2);
    inject_done = 1'b1;
    cyc(2);
    check("spurious_done_err", DW'(err_o), DW'(1'b1));
    cyc();
    check("spurious_done_err_pulse", DW'(err_o), DW'(1'b0));
    wait_results("spurious_done", 3000);

    // Reset in DIG clears everything including the keys.
    cyc(2);
    k = pass_cnt;
    push_msg(m_hi, 1'b1);
    start(2'd2);
    for (int i = 0; i < 300 && !(pass_cnt == k + 2 && core_buf.size() >= 17); i++) cyc();
    check("reached_dig", DW'(core_buf.size() >= 17 && pass_cnt == k + 2), DW'(1'b1));
    check("in_dig_busy", DW'(busy_o), DW'(1'b1));
    reset_i = 1'b1;
    cyc();
    check_all_zero("reset_in_dig");
    reset_i = 1'b0;
    cyc(10);
    check("final_queue_empty", DW'(exp_q.size()), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lw_hmac_ks.md
# lw_hmac_ks

HMAC sequencer with a multi-slot key store, parametrised in word width, digest length and slot count. It sits between the message/key ingress logic and an external streaming SHA core. The core pads its own input: it accepts words with a last flag and returns a digest. The sequencer wraps a caller's message stream in the inner (key⊕ipad) and outer (key⊕opad, digest) passes. Unlike the single-key generation, it holds NUM_KEYS pre-loaded keys, supports zeroization, aborts cleanly and flags misuse.

## Interface
- WORD_SIZE, 32: datapath word width; 32 or 64.
- DIGEST_WORDS, 8: core digest length in words (8 for SHA-256/SHA-512).
- NUM_KEYS, 4: number of key slots, ≥2; SW = $clog2(NUM_KEYS).
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- key_wr_i  in  1  write one key word.
- key_slot_i  in  SW  target slot for write/zeroize.
- key_idx_i  in  4  word index in block; 0 is sent first.
- key_i  in  WORD_SIZE  key word.
- key_zeroize_i  in  1  clear all 16 words of key_slot_i and its valid bit.
- key_valid_o  out  NUM_KEYS  per-slot bit; set by any write, cleared by zeroize.
- start_i / slot_i  in  1 / SW  begin HMAC with slot_i; sampled only in IDLE.
- abort_i  in  1  abandon the current operation.
- msg_valid_i, msg_data_i[WORD_SIZE], msg_last_i  in  message stream.
- msg_ready_o  out  1  message word accepted when msg_valid_i && msg_ready_o.
- core_start_o  out  1  one-cycle pulse that begins a new hash in the core.
- core_valid_o, core_data_o[WORD_SIZE], core_last_o  out  core input stream.
- core_ready_i  in  1  core accepts a word when core_valid_o && core_ready_i.
- core_done_i  in  1  one-cycle pulse; core_digest_i is valid that cycle.
- core_digest_i  in  DIGEST_WORDS*WORD_SIZE  core digest.
- core_abort_o  out  1  forwarded abort pulse.
- busy_o, done_o, err_o  out  1  status; done_o and err_o are one-cycle pulses.
- hmac_o  out  DIGEST_WORDS*WORD_SIZE  result; held until the next done_o.

## Operation
- Key store: NUM_KEYS×16 words. Short keys are zero-padded by the caller writing zero words. Key hashing for keys longer than one block is out of scope; the caller supplies H(K).
- If key_wr_i and key_zeroize_i target the same slot in the same cycle, zeroize wins.
- If a write or zeroize targets the active slot while busy_o=1, it is ignored and err_o pulses.
- FSM states: IDLE, IPAD, MSG, WAIT_IN, OPAD, DIG, WAIT_OUT.
- IDLE→IPAD on start_i when key_valid_o[slot_i]=1. The slot is latched and core_start_o pulses on entry.
- start_i on an invalid slot: err_o pulses and the FSM stays in IDLE.
- IPAD: 16 words, key[i]^{WORD_SIZE/8{8'h36}} for i=0..15, core_last_o=0, then →MSG.
- MSG: core_valid_o=msg_valid_i, core_data_o=msg_data_i, core_last_o=msg_last_i, msg_ready_o=core_ready_i. Transfer with last →WAIT_IN. An empty message is not supported; at least one word carrying last is required.
- WAIT_IN: on core_done_i, latch core_digest_i into an inner register, pulse core_start_o, →OPAD.
- OPAD: 16 words, key[i]^{8'h5c…}, then →DIG.
- DIG: DIGEST_WORDS words, most-significant first (core_digest_i[DIGEST_WORDS*WORD_SIZE-1 -: WORD_SIZE] first). core_last_o=1 on the final word. Then →WAIT_OUT.
- WAIT_OUT: on core_done_i, hmac_o<=core_digest_i, done_o=1 next cycle, →IDLE.
- abort_i in any non-IDLE state: →IDLE next cycle, core_abort_o=1 for one cycle, hmac_o unchanged, no done_o. The inner register is cleared to zero.
- core_done_i outside WAIT_IN/WAIT_OUT is ignored and pulses err_o.

## Timing
- Reset values:
  - state IDLE; all outputs 0.
  - key store all zeros; key_valid_o=0.
  - hmac_o=0; inner register 0.
- start_i at cycle t: core_start_o=1 at t+1. The first IPAD word has core_valid_o=1 at t+2.
- IPAD/OPAD/DIG: core_valid_o stays high. core_data_o is stable while core_ready_i=0. One word per cycle when core_ready_i=1.
- core_done_i at cycle c in WAIT_IN: core_start_o at c+1, first OPAD word at c+2.
- core_done_i at cycle c in WAIT_OUT: hmac_o updated and done_o=1 at c+1; busy_o=0 at c+1.
- busy_o=1 from the cycle after an accepted start_i until done_o or abort.
- start_i is ignored while busy_o=1.
- reset_i mid-operation returns every register to its reset value on the next edge. It also erases all keys.
- Internal word counter is 4 bits and wraps 15→0 on the IPAD→MSG and OPAD→DIG transitions. It reloads to 0 on every state entry.

## Test plan
- Slot 0 key "Jefe" (0x4a656665, then 15 zero words), WORD_SIZE=32, message "what do ya want for nothing?" (7 words, last on 7th), reference SHA-256 core model -> hmac_o = 5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843 with a single done_o pulse.
- Slot 2 key 20×0x0b, message "Hi There", core_ready_i toggling 1/0 randomly -> hmac_o = b0344c61d8db38535ca8afceaf0bf12b881dc200c9833da726e9376c2e32cff7; core_data_o is stable during every stall.
- start_i with slot_i=3 never written -> err_o pulses at t+1, core_start_o stays 0, busy_o stays 0.
- abort_i during MSG after 3 words -> core_abort_o pulses once, FSM returns to IDLE, hmac_o keeps its previous value. A following run on slot 0 reproduces scenario 1.
- key_zeroize_i on the active slot while busy -> err_o pulses and the result still matches. key_zeroize_i on slot 0 while idle -> key_valid_o[0]=0 and a subsequent start on slot 0 errors.
- Core stub that issues core_done_i during IPAD -> err_o pulses; reset_i asserted in DIG -> all outputs 0 and key_valid_o=0 next cycle.
